// File: rtl/behav_sram_1r1w_pipe_if.sv
// behav_sram_1r1w_pipe_if: write, read and clear-control bundle for behav_sram_1r1w_pipe
// master drives requests; slave (the memory) drives read results and status
interface behav_sram_1r1w_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 28,
    parameter int MASK_W = 8,
    parameter int CNT_W  = 16
);
    logic              W0_en;
    logic [ADDR_W-1:0] W0_addr;
    logic [DATA_W-1:0] W0_data;
    logic [MASK_W-1:0] W0_mask;
    logic              R0_en;
    logic [ADDR_W-1:0] R0_addr;
    logic [DATA_W-1:0] R0_data;
    logic              R0_valid;
    logic              clr_req;
    logic              busy;
    logic              clr_done;
    logic [CNT_W-1:0]  collision_cnt;

    modport master (
        output W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr, clr_req,
        input  R0_data, R0_valid, busy, clr_done, collision_cnt
    );

    modport slave (
        input  W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr, clr_req,
        output R0_data, R0_valid, busy, clr_done, collision_cnt
    );
endinterface

// File: rtl/behav_sram_1r1w_pipe.sv
// behav_sram_1r1w_pipe: behavioural 1R1W SRAM with masked writes, pipelined reads and a zero-fill sweep
// Define SRAM_GARBAGE_EN to drive random R0_data whenever R0_valid is low.
module behav_sram_1r1w_pipe #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 28,
    parameter int MASK_GRAN = 8,
    parameter int READ_LAT  = 1,
    parameter int RDW_MODE  = 0,
    parameter int CNT_W     = 16
) (
    input logic clock,
    input logic reset,
    behav_sram_1r1w_pipe_if.slave bus
);
    localparam int MASK_W = DATA_W / MASK_GRAN;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q;
    logic                busy_q;
    logic                clr_done_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [CNT_W-1:0]    coll_cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   bit_mask;
    logic [DATA_W-1:0]   merged_word;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_acc;
    logic                rd_acc;
    logic                same_addr;
    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] vld_d;
    logic [DATA_W-1:0]   dat_q [READ_LAT];
    logic [DATA_W-1:0]   dat_d [READ_LAT];

    assign wr_acc      = bus.W0_en && !busy_q;
    assign rd_acc      = bus.R0_en && !busy_q;
    assign same_addr   = wr_acc && rd_acc && (bus.W0_addr == bus.R0_addr);
    assign merged_word = (mem_q[bus.W0_addr] & ~bit_mask) | (bus.W0_data & bit_mask);
    assign rd_word     = (RDW_MODE == 1 && same_addr) ? merged_word : mem_q[bus.R0_addr];

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < MASK_W; i++)
            bit_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.W0_mask[i]}};
    end

    // Stage inputs: stage 0 takes the freshly sampled word, later stages shift
    always_comb begin
        vld_d[0] = rd_acc;
        dat_d[0] = rd_word;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (busy_q)
            mem_q[clr_cnt_q] <= '0;
        else if (wr_acc)
            mem_q[bus.W0_addr] <= merged_word;
    end

    // Data stages load only on a valid beat, so the last stage holds the previous result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < READ_LAT; i++)
                if (vld_d[i]) dat_q[i] <= dat_d[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            clr_cnt_q  <= '0;
        end else if (state_q == IDLE) begin
            clr_cnt_q <= '0;
            if (bus.clr_req) begin
                state_q <= CLEAR;
                busy_q  <= 1'b1;
            end
        end else begin
            clr_cnt_q  <= clr_cnt_q + 1'b1;
            clr_done_q <= clr_cnt_q == ADDR_W'(DEPTH - 2);
            if (clr_cnt_q == '1) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            coll_cnt_q <= '0;
        else if (same_addr && coll_cnt_q != '1)
            coll_cnt_q <= coll_cnt_q + 1'b1;
    end

    assign bus.R0_valid      = vld_q[READ_LAT-1];
    assign bus.busy          = busy_q;
    assign bus.clr_done      = clr_done_q;
    assign bus.collision_cnt = coll_cnt_q;

`ifdef SRAM_GARBAGE_EN
    logic [DATA_W-1:0] garbage_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            garbage_q <= '0;
        else
            for (int k = 0; k < DATA_W; k++) garbage_q[k] <= 1'($random);
    end

    assign bus.R0_data = vld_q[READ_LAT-1] ? dat_q[READ_LAT-1] : garbage_q;
`else
    assign bus.R0_data = dat_q[READ_LAT-1];
`endif
endmodule
